// File: rtl/gnw_frame_compositor.sv
// gnw_frame_compositor: renders emulated LCD segment state into a double-buffered byte-per-pixel framebuffer
// Ports: clk_sys/reset_n clock and async active-low reset; segA/segB/H/Bs live segment lines;
// disp_en/blank render control; rom_img_* image ROM read port; fb_* framebuffer write port;
// fb_page last completed page, frame completion pulse, busy frame in progress.
module gnw_frame_compositor #(
    parameter int          IMG_W    = 720,
    parameter int          IMG_H    = 480,
    parameter int          N_LINES  = 4,
    parameter int          FB_BYTES = 8,
    parameter logic [27:0] FB_PAGE0 = 28'h0000000,
    parameter logic [27:0] FB_PAGE1 = 28'h0060000
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [15:0]           segA,
    input  logic [15:0]           segB,
    input  logic [N_LINES-1:0]    H,
    input  logic                  Bs,
    input  logic                  disp_en,
    input  logic                  blank,
    output logic [24:0]           rom_img_addr,
    output logic                  rom_img_read,
    input  logic                  rom_img_data_ready,
    input  logic [7:0]            rom_img_data,
    output logic [27:0]           fb_addr,
    output logic [8*FB_BYTES-1:0] fb_data,
    output logic                  fb_req,
    input  logic                  fb_ready,
    output logic                  fb_page,
    output logic                  frame,
    output logic                  busy
);
    localparam int PW = $clog2(IMG_W*IMG_H+1);
    localparam int LW = $clog2(FB_BYTES);
    localparam logic [PW-1:0] P_TOT = PW'(IMG_W*IMG_H);
    typedef enum logic [2:0] {IDLE, MASK_REQ, MASK_WAIT, COLOR_REQ, COLOR_WAIT, PACK, FB_REQ, FB_WAIT} state_t;
    state_t         r_state;
    // Rows beyond N_LINES are never written, so they decode as 0.
    logic [15:0]    r_la [4];
    logic [15:0]    r_lb [4];
    logic [15:0]    r_ra [4];
    logic [15:0]    r_rb [4];
    logic [3:0]     r_ls, r_rs;
    logic [7:0]     r_mask;
    logic [24:0]    r_mask_addr;
    logic [PW-1:0]  r_pix;
    logic [LW-1:0]  r_lane;
    logic           r_wpage;
    logic [1:0]     w_hrow;
    logic [2:0]     w_hcnt;
    logic           w_on;
    logic [LW-1:0]  w_lane_nx;
    logic [PW-1:0]  w_pix_nx;
    always_comb begin
        w_hrow = '0;
        w_hcnt = '0;
        for (int i = 0; i < N_LINES; i++)
            if (H[i]) begin
                w_hrow = 2'(i);
                w_hcnt = w_hcnt + 3'd1;
            end
    end
    assign w_on = !blank && (r_mask[7:6] == 2'd0 ? r_ra[r_mask[1:0]][r_mask[5:2]] :
                             r_mask[7:6] == 2'd1 ? r_rb[r_mask[1:0]][r_mask[5:2]] :
                             r_mask[7:6] == 2'd2 ? r_rs[r_mask[1:0]] : 1'b0);
    assign w_lane_nx = r_lane + 1'b1;
    assign w_pix_nx  = r_pix + 1'b1;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            for (int i = 0; i < 4; i++) begin
                r_la[i] <= '0;
                r_lb[i] <= '0;
                r_ra[i] <= '0;
                r_rb[i] <= '0;
            end
            r_ls         <= '0;
            r_rs         <= '0;
            r_mask       <= '0;
            r_mask_addr  <= '0;
            r_pix        <= '0;
            r_lane       <= '0;
            r_wpage      <= 1'b0;
            rom_img_addr <= '0;
            rom_img_read <= 1'b0;
            fb_addr      <= FB_PAGE0;
            fb_data      <= '0;
            fb_req       <= 1'b0;
            fb_page      <= 1'b1;
            frame        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (w_hcnt == 3'd1) begin
                r_la[w_hrow] <= segA;
                r_lb[w_hrow] <= segB;
                r_ls[w_hrow] <= Bs;
            end
            frame <= 1'b0;
            case (r_state)
                IDLE: begin
                    busy <= disp_en;
                    if (disp_en) begin
                        // Nonblocking copy takes the pre-capture live value.
                        r_ra         <= r_la;
                        r_rb         <= r_lb;
                        r_rs         <= r_ls;
                        rom_img_addr <= '0;
                        r_mask_addr  <= '0;
                        r_pix        <= '0;
                        r_lane       <= '0;
                        fb_data      <= '0;
                        r_wpage      <= ~fb_page;
                        fb_addr      <= fb_page ? FB_PAGE0 : FB_PAGE1;
                        r_state      <= MASK_REQ;
                    end
                end
                MASK_REQ: if (disp_en) begin
                    rom_img_read <= 1'b1;
                    r_state      <= MASK_WAIT;
                end
                MASK_WAIT: if (rom_img_data_ready) begin
                    rom_img_read <= 1'b0;
                    r_mask       <= rom_img_data;
                    r_state      <= COLOR_REQ;
                end
                COLOR_REQ: begin
                    rom_img_addr <= r_mask_addr + (w_on ? 25'd1 : 25'd2);
                    rom_img_read <= 1'b1;
                    r_state      <= COLOR_WAIT;
                end
                COLOR_WAIT: if (rom_img_data_ready) begin
                    rom_img_read              <= 1'b0;
                    fb_data[r_lane*8 +: 8]    <= rom_img_data;
                    r_state                   <= PACK;
                end
                PACK: begin
                    r_lane       <= w_lane_nx;
                    r_pix        <= w_pix_nx;
                    r_mask_addr  <= r_mask_addr + 25'd3;
                    rom_img_addr <= r_mask_addr + 25'd3;
                    // A short final word is flushed with its unused lanes still zero.
                    r_state      <= (w_lane_nx == '0 || w_pix_nx == P_TOT) ? FB_REQ : MASK_REQ;
                end
                FB_REQ: begin
                    fb_req  <= 1'b1;
                    r_state <= FB_WAIT;
                end
                FB_WAIT: if (fb_ready) begin
                    fb_req  <= 1'b0;
                    fb_data <= '0;
                    fb_addr <= fb_addr + 28'(FB_BYTES);
                    r_lane  <= '0;
                    if (r_pix == P_TOT) begin
                        frame   <= 1'b1;
                        fb_page <= r_wpage;
                        r_state <= IDLE;
                    end else begin
                        r_state <= MASK_REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gnw_frame_compositor.sv
// tb_gnw_frame_compositor: directed frame vectors plus handshake, stall and reset sequences
module tb_gnw_frame_compositor;
    localparam logic [27:0] P0 = 28'h0000000;
    localparam logic [27:0] P1 = 28'h0060000;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] segA = '0, segB = '0;
    logic [3:0]  H = '0;
    logic        Bs = 1'b0, disp_en = 1'b0, blank = 1'b0;
    logic [24:0] rom_img_addr;
    logic        rom_img_read;
    logic        rom_img_data_ready = 1'b0;
    logic [7:0]  rom_img_data = '0;
    logic [27:0] fb_addr;
    logic [63:0] fb_data;
    logic        fb_req;
    logic        fb_ready = 1'b0;
    logic        fb_page, frame, busy;
    always #5 clk_sys = ~clk_sys;
    gnw_frame_compositor #(.IMG_W(4), .IMG_H(3), .N_LINES(4), .FB_BYTES(8), .FB_PAGE0(P0), .FB_PAGE1(P1)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .segA(segA), .segB(segB), .H(H), .Bs(Bs),
        .disp_en(disp_en), .blank(blank), .rom_img_addr(rom_img_addr), .rom_img_read(rom_img_read),
        .rom_img_data_ready(rom_img_data_ready), .rom_img_data(rom_img_data), .fb_addr(fb_addr),
        .fb_data(fb_data), .fb_req(fb_req), .fb_ready(fb_ready), .fb_page(fb_page), .frame(frame), .busy(busy));
    int total = 0, bad = 0;
    int max_dly = 0;
    logic [7:0]  rom [36];
    logic [27:0] wq_a [$];
    logic [63:0] wq_d [$];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    int rdly = 0;
    logic rpend = 1'b0;
    logic [24:0] ra0 = '0;
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            rom_img_data_ready = 1'b0;
            rpend = 1'b0;
        end else if (rom_img_data_ready) begin
            rom_img_data_ready = 1'b0;
        end else if (rom_img_read) begin
            if (!rpend) begin
                rpend = 1'b1;
                ra0 = rom_img_addr;
                rdly = $urandom_range(0, max_dly);
            end else chk("rom_addr_stable", 64'(rom_img_addr), 64'(ra0));
            if (rdly == 0) begin
                rom_img_data_ready = 1'b1;
                rom_img_data = (rom_img_addr < 25'd36) ? rom[rom_img_addr[5:0]] : 8'hEE;
                rpend = 1'b0;
            end else rdly--;
        end else if (rpend) begin
            chk("rom_read_held", 64'(rom_img_read), 64'd1);
            rpend = 1'b0;
        end
    end
    int fdly = 0;
    logic fpend = 1'b0;
    logic [27:0] fa0 = '0;
    logic [63:0] fd0 = '0;
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            fb_ready = 1'b0;
            fpend = 1'b0;
        end else if (fb_ready) begin
            fb_ready = 1'b0;
        end else if (fb_req) begin
            if (!fpend) begin
                fpend = 1'b1;
                fa0 = fb_addr;
                fd0 = fb_data;
                fdly = $urandom_range(0, max_dly);
            end else begin
                chk("fb_addr_stable", 64'(fb_addr), 64'(fa0));
                chk("fb_data_stable", fb_data, fd0);
            end
            if (fdly == 0) begin
                fb_ready = 1'b1;
                wq_a.push_back(fb_addr);
                wq_d.push_back(fb_data);
                fpend = 1'b0;
            end else fdly--;
        end else if (fpend) begin
            chk("fb_req_held", 64'(fb_req), 64'd1);
            fpend = 1'b0;
        end
    end
    typedef struct packed {
        logic [3:0][15:0] la;
        logic [3:0][15:0] lb;
        logic [3:0]       ls;
        logic             blk;
        int               dly;
        logic [63:0]      w0;
        logic [63:0]      w1;
        logic             pg;
    } vec_t;
    vec_t v [5];
    task automatic load(input logic [3:0][15:0] la, input logic [3:0][15:0] lb, input logic [3:0] ls);
        for (int r = 0; r < 4; r++) begin
            @(negedge clk_sys);
            H = 4'(1 << r);
            segA = la[r];
            segB = lb[r];
            Bs = ls[r];
        end
        @(negedge clk_sys);
        H = '0;
    endtask
    task automatic wait_frame(output int cyc);
        cyc = 0;
        while (!frame && cyc < 5000) begin
            @(negedge clk_sys);
            cyc++;
        end
        chk("frame_seen", 64'(frame), 64'd1);
        disp_en = 1'b0;
        chk("busy_at_frame", 64'(busy), 64'd1);
        @(negedge clk_sys);
        chk("frame_pulse_end", 64'(frame), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
    endtask
    task automatic check_words(input string tag, input logic [63:0] w0, input logic [63:0] w1, input logic pg);
        logic [27:0] base;
        base = pg ? P1 : P0;
        chk({tag, "_nwords"}, 64'(wq_d.size()), 64'd2);
        if (wq_d.size() == 2) begin
            chk({tag, "_addr0"}, 64'(wq_a[0]), 64'(base));
            chk({tag, "_word0"}, wq_d[0], w0);
            chk({tag, "_addr1"}, 64'(wq_a[1]), 64'(base + 28'd8));
            chk({tag, "_word1"}, wq_d[1], w1);
        end
        chk({tag, "_page"}, 64'(fb_page), 64'(pg));
    endtask
    task automatic run_frame(input string tag, input int dly, input logic [63:0] w0, input logic [63:0] w1,
                             input logic pg, output int cyc);
        wq_a.delete();
        wq_d.delete();
        max_dly = dly;
        @(negedge clk_sys);
        disp_en = 1'b1;
        wait_frame(cyc);
        check_words(tag, w0, w1, pg);
    endtask
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rom_addr"}, 64'(rom_img_addr), 64'd0);
        chk({tag, "_rom_read"}, 64'(rom_img_read), 64'd0);
        chk({tag, "_fb_addr"}, 64'(fb_addr), 64'(P0));
        chk({tag, "_fb_data"}, fb_data, 64'd0);
        chk({tag, "_fb_req"}, 64'(fb_req), 64'd0);
        chk({tag, "_fb_page"}, 64'(fb_page), 64'd1);
        chk({tag, "_frame"}, 64'(frame), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask
    initial begin
        logic [7:0] masks [12];
        int cyc;
        masks = '{8'h00, 8'h41, 8'h80, 8'hC0, 8'h05, 8'h7F, 8'h83, 8'h3E, 8'h44, 8'h02, 8'hFF, 8'h81};
        for (int p = 0; p < 12; p++) begin
            rom[3*p]   = masks[p];
            rom[3*p+1] = 8'(8'hA0 + p);
            rom[3*p+2] = 8'(8'h50 + p);
        end
        v[0] = '{la: {16'h0, 16'h0, 16'h0, 16'h0001}, lb: '0, ls: 4'b0001, blk: 1'b0, dly: 0,
                 w0: 64'h57565554_53A251A0, w1: 64'h00000000_5B5A5958, pg: 1'b0};
        v[1] = '{la: {4{16'hFFFF}}, lb: {4{16'hFFFF}}, ls: 4'hF, blk: 1'b0, dly: 3,
                 w0: 64'hA7A6A5A4_53A2A1A0, w1: 64'h00000000_AB5AA9A8, pg: 1'b1};
        v[2] = '{la: {4{16'hFFFF}}, lb: {4{16'hFFFF}}, ls: 4'hF, blk: 1'b1, dly: 7,
                 w0: 64'h57565554_53525150, w1: 64'h00000000_5B5A5958, pg: 1'b0};
        v[3] = '{la: {16'h0, 16'h8000, 16'h0002, 16'h0}, lb: {16'h8000, 16'h0, 16'h0, 16'h0}, ls: 4'b1000,
                 blk: 1'b0, dly: 7, w0: 64'hA7A6A5A4_53525150, w1: 64'h00000000_5B5A5958, pg: 1'b1};
        v[4] = '{la: {16'h0, 16'h0001, 16'h0, 16'h0}, lb: {16'h0, 16'h0, 16'h0, 16'h0002}, ls: 4'b0010,
                 blk: 1'b0, dly: 5, w0: 64'h57565554_53525150, w1: 64'h00000000_AB5AA9A8, pg: 1'b0};
        repeat (3) @(negedge clk_sys);
        chk_reset_vals("por");
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load(v[i].la, v[i].lb, v[i].ls);
            blank = v[i].blk;
            run_frame($sformatf("vec%0d", i), v[i].dly, v[i].w0, v[i].w1, v[i].pg, cyc);
            if (v[i].dly == 0) chk("latency", 64'(cyc), 64'd65);
            blank = 1'b0;
        end
        // Zero and multi-hot H must not touch any row.
        @(negedge clk_sys);
        segA = 16'hFFFF;
        segB = 16'hFFFF;
        Bs = 1'b1;
        H = 4'b0000;
        repeat (3) @(negedge clk_sys);
        H = 4'b0110;
        repeat (3) @(negedge clk_sys);
        H = 4'b0000;
        run_frame("badh", 2, v[4].w0, v[4].w1, 1'b1, cyc);
        // Row 0 change during a frame shows up only in the following frame.
        fork
            run_frame("midchg", 2, v[4].w0, v[4].w1, 1'b0, cyc);
            begin
                repeat (10) @(negedge clk_sys);
                chk("midchg_busy", 64'(busy), 64'd1);
                H = 4'b0001;
                segA = 16'h0001;
                segB = 16'h0002;
                Bs = 1'b0;
                @(negedge clk_sys);
                H = 4'b0000;
            end
        join
        run_frame("after_chg", 0, 64'h57565554_535251A0, v[4].w1, 1'b1, cyc);
        chk("after_chg_latency", 64'(cyc), 64'd65);
        // disp_en low while the first word is pending: word completes, then stall without reads.
        wq_a.delete();
        wq_d.delete();
        max_dly = 1;
        @(negedge clk_sys);
        disp_en = 1'b1;
        cyc = 0;
        while (!fb_req && cyc < 2000) begin
            @(negedge clk_sys);
            cyc++;
        end
        chk("stall_fb_req_seen", 64'(fb_req), 64'd1);
        disp_en = 1'b0;
        repeat (20) @(negedge clk_sys);
        chk("stall_words", 64'(wq_d.size()), 64'd1);
        chk("stall_word0", (wq_d.size() > 0) ? wq_d[0] : 64'd0, 64'h57565554_535251A0);
        chk("stall_no_read", 64'(rom_img_read), 64'd0);
        chk("stall_no_req", 64'(fb_req), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        disp_en = 1'b1;
        wait_frame(cyc);
        check_words("resume", 64'h57565554_535251A0, v[4].w1, 1'b0);
        // Reset mid-frame clears outputs and segment state; next frame goes to page 0.
        max_dly = 0;
        @(negedge clk_sys);
        disp_en = 1'b1;
        repeat (15) @(negedge clk_sys);
        chk("rst_pre_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        disp_en = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        run_frame("postrst", 0, 64'h57565554_53525150, 64'h00000000_5B5A5958, 1'b0, cyc);
        chk("postrst_latency", 64'(cyc), 64'd65);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
